multicycle_control_fsm: RTL
===========================

Name: multicycle_control_fsm

Overview:
Main controller for the multi-cycle RV32IM datapath. It sits directly upstream of the ALU and drives its 4-bit ALUcontrol and both operand-select muxes. It also sequences fetch, decode, execute, memory and writeback, one state per cycle. It consumes the ALU zero flag to resolve branches.

Parameters:
ENABLE_M, 1, when 1 the R-type funct7=0000001 group decodes to MUL/MULH/MULHSU/MULHU/DIV/DIVU; when 0 that group is illegal

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous active-high reset
opcode  in  7  instr[6:0] from instruction register
funct3  in  3  instr[14:12]
funct7  in  7  instr[31:25]
zero  in  1  ALU zero flag (ALUresult==0), combinational from ALU in the current cycle
PCWrite  out  1  load PC
AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut
MemWrite  out  1  data memory write strobe
IRWrite  out  1  load instruction register and OldPC
RegWrite  out  1  register file write
ResultSrc  out  2  00=ALUOut, 01=MemData, 10=ALUresult (direct)
ALUSrcA  out  2  00=PC, 01=OldPC, 10=reg A (rs1), 11=constant 0
ALUSrcB  out  2  00=reg B (rs2), 01=ImmExt, 10=constant 4
ImmSrc  out  3  000=I, 001=S, 010=B, 011=J, 100=U
ALUcontrol  out  4  ALU op; encoding below
illegal_instr  out  1  sticky illegal-instruction flag
state_o  out  4  current state, for debug/verification

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high.
- Reset:
  - state <= FETCH (0000) and illegal_instr <= 0 on the clk edge where reset=1.
  - Reset mid-instruction aborts that instruction; no partial write occurs in the following cycle.
- ALUcontrol encoding:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA
  - 1000 SLT, 1001 SLTU, 1010 MUL, 1011 MULH, 1100 MULHSU, 1101 MULHU, 1110 DIV, 1111 DIVU
- Output timing:
  - All control outputs are combinational from state plus instruction fields.
  - Any output not listed for a state is 0, and ALUcontrol defaults to ADD.
  - ImmSrc is decoded from opcode in every state: lw/I-ALU/jalr=I, sw=S, branch=B, jal=J, lui/auipc=U.
- States (encoding), per-state outputs, and next state:
  - FETCH (0): AdrSrc=0, IRWrite=1, SrcA=00, SrcB=10, ADD, ResultSrc=10, PCWrite=1 -> DECODE.
  - DECODE (1): SrcA=01, SrcB=01, ADD (branch/jal target into ALUOut). Next state by opcode:
    - 0000011 (lw) or 0100011 (sw) -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - 1100111 -> JALR
    - 0110111 -> LUI
    - 0010111 -> AUIPC
    - otherwise -> ILLEGAL
  - MEMADR (2): SrcA=10, SrcB=01, ADD -> MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD (3): AdrSrc=1 -> MEMWB.
  - MEMWB (4): ResultSrc=01, RegWrite=1 -> FETCH.
  - MEMWRITE (5): AdrSrc=1, MemWrite=1 -> FETCH.
  - EXECR (6): SrcA=10, SrcB=00, ALUcontrol from funct7/funct3 -> ALUWB.
  - EXECI (7): SrcA=10, SrcB=01, ALUcontrol from funct3 (funct7 only for shifts) -> ALUWB.
  - ALUWB (8): ResultSrc=00, RegWrite=1 -> FETCH.
  - BRANCH (9): SrcA=10, SrcB=00, ResultSrc=00. PCWrite=taken -> FETCH. Comparison by funct3:
    - beq (000): SUB, taken = zero
    - bne (001): SUB, taken = !zero
    - blt (100): SLT, taken = !zero
    - bge (101): SLT, taken = zero
    - bltu (110): SLTU, taken = !zero
    - bgeu (111): SLTU, taken = zero
  - JAL (10): SrcA=01, SrcB=10, ADD, ResultSrc=00, PCWrite=1 -> ALUWB (rd <= OldPC+4).
  - JALR (11): SrcA=10, SrcB=01, ADD -> JAL (reuses the JAL link/jump state).
  - LUI (12): SrcA=11, SrcB=01, ADD -> ALUWB.
  - AUIPC (13): SrcA=01, SrcB=01, ADD -> ALUWB.
  - ILLEGAL (15): all writes 0, illegal_instr=1; holds until reset.
- Illegal decodes (-> ILLEGAL from the decision state, no writes issued):
  - Detected in DECODE:
    - branch funct3 010 or 011
    - lw/sw funct3 != 010
    - jalr funct3 != 000
  - R-type, detected in EXECR:
    - funct7 not in {0000000, 0100000, 0000001}
    - 0100000 with funct3 not in {000, 101}
    - 0000001 with funct3 in {110, 111} (REM/REMU unsupported)
    - 0000001 with ENABLE_M=0
  - I-type, detected in EXECI:
    - slli with funct7 != 0000000
    - srli/srai with funct7 not in {0000000, 0100000}
- R-type mapping:
  - funct7 0000000, by funct3: 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND
  - funct7 0100000: 000 SUB, 101 SRA
  - funct7 0000001: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU
- I-type mapping: as funct7=0000000, except funct3=000 is always ADD and 101 with funct7=0100000 is SRA.
- State 14 (unused): illegal_instr=1 -> ILLEGAL.
- Latency:
  - lw 5 cycles
  - sw, R-type, I-type, lui, auipc 4 cycles
  - branch 3 cycles
  - jal 4 cycles
  - jalr 5 cycles

Test Plan:
- Reset asserted for 2 cycles mid-MEMWRITE, then released -> MemWrite=0 in the reset cycle; state_o=0, IRWrite=1, PCWrite=1 on the first cycle after release.
- opcode=0110011, funct7=0000001, funct3=001 (mulh) -> state_o sequence 0,1,6,8,0; ALUcontrol=1011 in EXECR; RegWrite=1 only in ALUWB.
- bne x1,x2 with zero=0 in BRANCH -> ALUcontrol=0001, PCWrite=1, ResultSrc=00. Repeat with zero=1 -> PCWrite=0. Both return to FETCH.
- bgeu, opcode=1100011, funct3=111, zero=1 -> ALUcontrol=1001, PCWrite=1.
- lw (0000011/010) -> states 0,1,2,3,4,0; ImmSrc=000; AdrSrc=1 in MEMREAD; ResultSrc=01 and RegWrite=1 in MEMWB. jalr (1100111/000) -> states 0,1,11,10,8,0.
- Illegal cases:
  - funct7=0100000, funct3=111 (R-type) -> state_o=15, illegal_instr=1, stays 15 for 10 cycles, cleared only by reset.
  - ENABLE_M=0 with mul -> ILLEGAL.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_control_fsm
//
// Main controller for the multi-cycle RV32IM datapath. It sequences each
// instruction through fetch / decode / execute / memory / writeback, one state
// per cycle. It drives the ALU operation and both ALU operand-select muxes, and
// it uses the ALU zero flag to resolve branches.
//
// Ports
//   clk           in   clock, all state updates on the rising edge
//   reset         in   synchronous, active-high reset
//   opcode        in   [6:0]   instr[6:0] from the instruction register
//   funct3        in   [2:0]   instr[14:12]
//   funct7        in   [6:0]   instr[31:25]
//   zero          in   ALU zero flag for the current cycle
//   PCWrite       out  load PC
//   AdrSrc        out  memory address: 0=PC, 1=ALUOut
//   MemWrite      out  data memory write strobe
//   IRWrite       out  load instruction register and OldPC
//   RegWrite      out  register file write
//   ResultSrc     out  [1:0]  00=ALUOut, 01=MemData, 10=ALUresult
//   ALUSrcA       out  [1:0]  00=PC, 01=OldPC, 10=rs1, 11=constant 0
//   ALUSrcB       out  [1:0]  00=rs2, 01=ImmExt, 10=constant 4
//   ImmSrc        out  [2:0]  000=I, 001=S, 010=B, 011=J, 100=U
//   ALUcontrol    out  [3:0]  ALU operation
//   illegal_instr out  sticky illegal-instruction flag
//   state_o       out  [3:0]  current state, for debug
//
// All control outputs are combinational from the state and instruction fields.
// While reset is high every write strobe is forced low, so an instruction cut
// off by reset never leaves a partial write behind.
// -----------------------------------------------------------------------------
module multicycle_control_fsm #(
    parameter logic ENABLE_M = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ImmSrc,
    output logic [3:0] ALUcontrol,
    output logic       illegal_instr,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        JALR     = 4'd11,
        LUI      = 4'd12,
        AUIPC    = 4'd13,
        UNUSED   = 4'd14,
        ILLEGAL  = 4'd15
    } state_t;

    // opcodes
    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // funct7 groups
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    // ALU operations
    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_SUB    = 4'b0001;
    localparam logic [3:0] ALU_AND    = 4'b0010;
    localparam logic [3:0] ALU_OR     = 4'b0011;
    localparam logic [3:0] ALU_XOR    = 4'b0100;
    localparam logic [3:0] ALU_SLL    = 4'b0101;
    localparam logic [3:0] ALU_SRL    = 4'b0110;
    localparam logic [3:0] ALU_SRA    = 4'b0111;
    localparam logic [3:0] ALU_SLT    = 4'b1000;
    localparam logic [3:0] ALU_SLTU   = 4'b1001;
    localparam logic [3:0] ALU_MUL    = 4'b1010;
    localparam logic [3:0] ALU_MULH   = 4'b1011;
    localparam logic [3:0] ALU_MULHSU = 4'b1100;
    localparam logic [3:0] ALU_MULHU  = 4'b1101;
    localparam logic [3:0] ALU_DIV    = 4'b1110;
    localparam logic [3:0] ALU_DIVU   = 4'b1111;

    state_t state, next_state;
    logic   illegal_q;

    // decode helpers
    logic [3:0] r_alu;
    logic       r_ok;
    logic [3:0] i_alu;
    logic       i_ok;
    logic [3:0] br_alu;
    logic       br_taken;

    // -------------------------------------------------------------------------
    // State register and sticky illegal flag
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FETCH;
            illegal_q <= 1'b0;
        end else begin
            state <= next_state;
            if (next_state == ILLEGAL) begin
                illegal_q <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // R-type ALU decode (funct7 / funct3)
    // -------------------------------------------------------------------------
    always_comb begin
        r_alu = ALU_ADD;
        r_ok  = 1'b1;
        case (funct7)
            F7_BASE: begin
                case (funct3)
                    3'b000:  r_alu = ALU_ADD;
                    3'b001:  r_alu = ALU_SLL;
                    3'b010:  r_alu = ALU_SLT;
                    3'b011:  r_alu = ALU_SLTU;
                    3'b100:  r_alu = ALU_XOR;
                    3'b101:  r_alu = ALU_SRL;
                    3'b110:  r_alu = ALU_OR;
                    default: r_alu = ALU_AND;
                endcase
            end
            F7_ALT: begin
                case (funct3)
                    3'b000:  r_alu = ALU_SUB;
                    3'b101:  r_alu = ALU_SRA;
                    default: r_ok  = 1'b0;
                endcase
            end
            F7_MUL: begin
                if (!ENABLE_M) begin
                    r_ok = 1'b0;
                end else begin
                    case (funct3)
                        3'b000:  r_alu = ALU_MUL;
                        3'b001:  r_alu = ALU_MULH;
                        3'b010:  r_alu = ALU_MULHSU;
                        3'b011:  r_alu = ALU_MULHU;
                        3'b100:  r_alu = ALU_DIV;
                        3'b101:  r_alu = ALU_DIVU;
                        default: r_ok  = 1'b0;
                    endcase
                end
            end
            default: r_ok = 1'b0;
        endcase
    end

    // -------------------------------------------------------------------------
    // I-type ALU decode: funct7 only matters for the shift encodings
    // -------------------------------------------------------------------------
    always_comb begin
        i_alu = ALU_ADD;
        i_ok  = 1'b1;
        case (funct3)
            3'b000: i_alu = ALU_ADD;
            3'b001: begin
                i_alu = ALU_SLL;
                if (funct7 != F7_BASE) begin
                    i_ok = 1'b0;
                end
            end
            3'b010: i_alu = ALU_SLT;
            3'b011: i_alu = ALU_SLTU;
            3'b100: i_alu = ALU_XOR;
            3'b101: begin
                if (funct7 == F7_BASE) begin
                    i_alu = ALU_SRL;
                end else if (funct7 == F7_ALT) begin
                    i_alu = ALU_SRA;
                end else begin
                    i_ok = 1'b0;
                end
            end
            3'b110:  i_alu = ALU_OR;
            default: i_alu = ALU_AND;
        endcase
    end

    // -------------------------------------------------------------------------
    // Branch compare: SUB for equality, SLT/SLTU for ordering. For the
    // ordering compares the ALU result is 1 when rs1 < rs2, so "less than"
    // is taken on !zero and "greater or equal" on zero.
    // -------------------------------------------------------------------------
    always_comb begin
        br_alu   = ALU_SUB;
        br_taken = 1'b0;
        case (funct3)
            3'b000: begin br_alu = ALU_SUB;  br_taken = zero;  end
            3'b001: begin br_alu = ALU_SUB;  br_taken = !zero; end
            3'b100: begin br_alu = ALU_SLT;  br_taken = !zero; end
            3'b101: begin br_alu = ALU_SLT;  br_taken = zero;  end
            3'b110: begin br_alu = ALU_SLTU; br_taken = !zero; end
            3'b111: begin br_alu = ALU_SLTU; br_taken = zero;  end
            default: begin br_alu = ALU_SUB; br_taken = 1'b0;  end
        endcase
    end

    // -------------------------------------------------------------------------
    // Next state and control outputs
    // -------------------------------------------------------------------------
    always_comb begin
        next_state    = state;
        PCWrite       = 1'b0;
        AdrSrc        = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        RegWrite      = 1'b0;
        ResultSrc     = 2'b00;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        ImmSrc        = 3'b000;
        ALUcontrol    = ALU_ADD;
        illegal_instr = illegal_q;

        // immediate format follows the opcode in every state
        case (opcode)
            OP_SW:             ImmSrc = 3'b001;
            OP_BRANCH:         ImmSrc = 3'b010;
            OP_JAL:            ImmSrc = 3'b011;
            OP_LUI, OP_AUIPC:  ImmSrc = 3'b100;
            default:           ImmSrc = 3'b000;
        endcase

        case (state)
            FETCH: begin
                AdrSrc     = 1'b0;
                IRWrite    = 1'b1;
                ALUSrcA    = 2'b00;
                ALUSrcB    = 2'b10;
                ALUcontrol = ALU_ADD;
                ResultSrc  = 2'b10;
                PCWrite    = 1'b1;
                next_state = DECODE;
            end
            DECODE: begin
                // OldPC + imm lands in ALUOut for branch/jal targets
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b01;
                ALUcontrol = ALU_ADD;
                case (opcode)
                    OP_LW, OP_SW: next_state = (funct3 == 3'b010) ? MEMADR : ILLEGAL;
                    OP_R:         next_state = EXECR;
                    OP_I:         next_state = EXECI;
                    OP_BRANCH:    next_state = (funct3[2:1] == 2'b01) ? ILLEGAL : BRANCH;
                    OP_JAL:       next_state = JAL;
                    OP_JALR:      next_state = (funct3 == 3'b000) ? JALR : ILLEGAL;
                    OP_LUI:       next_state = LUI;
                    OP_AUIPC:     next_state = AUIPC;
                    default:      next_state = ILLEGAL;
                endcase
            end
            MEMADR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUcontrol = ALU_ADD;
                next_state = (opcode == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                AdrSrc     = 1'b1;
                next_state = MEMWB;
            end
            MEMWB: begin
                ResultSrc  = 2'b01;
                RegWrite   = 1'b1;
                next_state = FETCH;
            end
            MEMWRITE: begin
                AdrSrc     = 1'b1;
                MemWrite   = 1'b1;
                next_state = FETCH;
            end
            EXECR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b00;
                ALUcontrol = r_ok ? r_alu : ALU_ADD;
                next_state = r_ok ? ALUWB : ILLEGAL;
            end
            EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUcontrol = i_ok ? i_alu : ALU_ADD;
                next_state = i_ok ? ALUWB : ILLEGAL;
            end
            ALUWB: begin
                ResultSrc  = 2'b00;
                RegWrite   = 1'b1;
                next_state = FETCH;
            end
            BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b00;
                ResultSrc  = 2'b00;
                ALUcontrol = br_alu;
                PCWrite    = br_taken;
                next_state = FETCH;
            end
            JAL: begin
                // PC <= ALUOut (target), ALU computes OldPC + 4 for the link
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                ALUcontrol = ALU_ADD;
                ResultSrc  = 2'b00;
                PCWrite    = 1'b1;
                next_state = ALUWB;
            end
            JALR: begin
                // rs1 + imm replaces the target in ALUOut, then reuse JAL
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUcontrol = ALU_ADD;
                next_state = JAL;
            end
            LUI: begin
                ALUSrcA    = 2'b11;
                ALUSrcB    = 2'b01;
                ALUcontrol = ALU_ADD;
                next_state = ALUWB;
            end
            AUIPC: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b01;
                ALUcontrol = ALU_ADD;
                next_state = ALUWB;
            end
            UNUSED: begin
                illegal_instr = 1'b1;
                next_state    = ILLEGAL;
            end
            ILLEGAL: begin
                illegal_instr = 1'b1;
                next_state    = ILLEGAL;
            end
            default: begin
                illegal_instr = 1'b1;
                next_state    = ILLEGAL;
            end
        endcase

        // reset aborts the current instruction without any write
        if (reset) begin
            PCWrite  = 1'b0;
            MemWrite = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
        end
    end

    assign state_o = state;

endmodule
